// File: rtl/uart_pkg.sv
// Shared UART defaults and the receive FIFO entry layout.
// Each FIFO entry is packed as {err, data}.
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 4;
  localparam int ENTRY_WIDTH        = UART_DATA_WIDTH + 1;

  function automatic int entry_width(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Receive FIFO storage: register array, one write port,
// one read port with a registered, enable-gated output.
module rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int AW = RX_FIFO_DEPTH_LOG2,
  parameter int EW = ENTRY_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  logic [EW-1:0] mem_q [2**AW];
  logic [EW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_byte_fifo.sv
// UART receive byte FIFO with registered valid/ready read port.
// Define RX_FIFO_DROP_BAD_EN to discard frames with a parity error.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] received_data,
  input  logic                  data_is_valid,
  input  logic                  rx_error,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int PW = DEPTH_LOG2 + 1;

`ifdef RX_FIFO_DROP_BAD_EN
  localparam logic KEEP_ERR = 1'b0;
`else
  localparam logic KEEP_ERR = 1'b1;
`endif

  logic          dv_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;

  logic          wr_evt;
  logic          frame_ok;
  logic          full;
  logic          rd_fire;
  logic          wr_en;
  logic          ovf_set;
  logic          mem_re;
  logic [EW-1:0] mem_wdata;
  logic [EW-1:0] mem_rdata;

  assign wr_evt   = data_is_valid & ~dv_q;
  assign frame_ok = KEEP_ERR | ~rx_error;
  assign full     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0])
                  & (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign rd_fire  = rd_valid_q & rd_ready;
  assign wr_en    = wr_evt & frame_ok & (~full | rd_fire);
  assign ovf_set  = wr_evt & frame_ok & full & ~rd_fire;

  // Output register only reloads when it is empty or being consumed.
  assign mem_re    = ~rd_valid_q | rd_ready;
  assign mem_wdata = {rx_error & KEEP_ERR, received_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_fire);
    level_d  = wr_ptr_d - rd_ptr_d;
    // Only entries written before this edge are readable at the output.
    rd_valid_d = (wr_ptr_q != rd_ptr_d);
    ovf_d = ovf_q;
    if (clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dv_q       <= data_is_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  rx_fifo_mem #(
    .AW (DEPTH_LOG2),
    .EW (EW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_d[DEPTH_LOG2-1:0]),
    .rdata_o (mem_rdata)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata[DATA_WIDTH-1:0];
  assign rd_err   = mem_rdata[DATA_WIDTH] & KEEP_ERR;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo with a queue-based reference model.
// Honours RX_FIFO_DROP_BAD_EN when defined for the build.
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       dv, rxe, rdy, clr;
  logic       rd_valid, rd_err, overflow;
  logic [7:0] rd_data;
  logic [4:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  bit go = 0;

  always #5 clk = ~clk;

  rx_byte_fifo dut (
    .clk           (clk),
    .reset         (rst_n),
    .received_data (din),
    .data_is_valid (dv),
    .rx_error      (rxe),
    .rd_valid      (rd_valid),
    .rd_ready      (rdy),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .level         (level),
    .overflow      (overflow),
    .clr_overflow  (clr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries tagged with the edge that wrote them.
  typedef struct {
    logic [7:0]  d;
    logic        e;
    int unsigned wc;
  } ent_t;

  ent_t        mq[$];
  int unsigned ecount = 0;
  bit          m_prev = 0;
  bit          m_ovf = 0;
  bit          m_rdv = 0;

  always @(posedge clk or negedge rst_n) begin
    bit hs, evt, keep, set;
    int sz0;
    if (!rst_n) begin
      mq.delete();
      m_prev = 0;
      m_ovf  = 0;
    end else begin
      hs  = m_rdv && rdy;
      evt = dv && !m_prev;
      m_prev = dv;
      sz0 = mq.size();
      set = 0;
      ecount++;
      if (hs) void'(mq.pop_front());
`ifdef RX_FIFO_DROP_BAD_EN
      keep = !rxe;
`else
      keep = 1;
`endif
      if (evt && keep) begin
        if (sz0 < 16 || hs) mq.push_back('{d: din, e: rxe, wc: ecount});
        else set = 1;
      end
      if (set) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    m_rdv = (mq.size() > 0) && (mq[0].wc < ecount);
  end

  always @(negedge clk) begin
    if (go) begin
      chk("level", level, mq.size());
      chk("rd_valid", rd_valid, m_rdv);
      chk("overflow", overflow, m_ovf);
      if (m_rdv) begin
        chk("rd_data", rd_data, mq[0].d);
`ifdef RX_FIFO_DROP_BAD_EN
        chk("rd_err", rd_err, 0);
`else
        chk("rd_err", rd_err, mq[0].e);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic e, input int hold);
    dv = 1; din = d; rxe = e;
    repeat (hold) tick();
    dv = 0; rxe = 0;
    tick();
  endtask

  task automatic drain();
    rdy = 1;
    for (int k = 0; k < 200; k++) begin
      if (level == 0 && !rd_valid) break;
      tick();
    end
    rdy = 0;
    chk("drain_level", level, 0);
    chk("drain_valid", rd_valid, 0);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) send(base + 8'(i), 0, 1);
  endtask

  initial begin
    logic [7:0] last;
    rst_n = 0; dv = 0; din = 0; rxe = 0; rdy = 0; clr = 0;
    repeat (3) tick();
    rst_n = 1;
    go = 1;
    chk("rst_level", level, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_err", rd_err, 0);

    // reset mid-stream
    send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1);
    chk("t1_level3", level, 3);
    rst_n = 0;
    tick();
    chk("t1_rlevel", level, 0);
    chk("t1_rvalid", rd_valid, 0);
    chk("t1_rovf", overflow, 0);
    rst_n = 1;
    send(8'h5A, 0, 1);
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 8'h5A);
    drain();

    // long pulse, single write
    dv = 1; din = 8'hA5; rxe = 0;
    tick();
    chk("t2_level_e", level, 1);
    chk("t2_valid_e", rd_valid, 0);
    tick();
    chk("t2_valid", rd_valid, 1);
    chk("t2_data", rd_data, 8'hA5);
    chk("t2_err", rd_err, 0);
    tick(); tick();
    dv = 0;
    tick();
    chk("t2_level", level, 1);
    drain();

    // fill, overflow, ordered back-to-back drain
    fill(8'h00);
    chk("t3_full", level, 16);
    chk("t3_ovf0", overflow, 0);
    send(8'h10, 0, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_lvl", level, 16);
    rdy = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_bvalid", rd_valid, 1);
      chk("t3_bdata", rd_data, i);
      tick();
    end
    rdy = 0;
    tick();
    chk("t3_empty", level, 0);
    clr = 1;
    tick();
    clr = 0;
    chk("t3_clr", overflow, 0);

    // full + write with simultaneous read
    fill(8'h30);
    dv = 1; din = 8'h20; rdy = 1;
    tick();
    dv = 0; rdy = 0;
    tick();
    chk("t4_level", level, 16);
    chk("t4_ovf", overflow, 0);
    rdy = 1;
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rd_data;
      tick();
    end
    rdy = 0;
    chk("t4_last", last, 8'h20);
    tick();
    rdy = 1;
    for (int i = 0; i < 40; i++) send(8'h40 + 8'(i), 0, 1);
    drain();

    // set beats clear in the same cycle
    fill(8'h60);
    dv = 1; din = 8'h70; clr = 1;
    tick();
    dv = 0; clr = 0;
    chk("t5_set", overflow, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("t5_clr", overflow, 0);
    drain();

    // parity-error frame
    send(8'h3C, 1, 1);
`ifdef RX_FIFO_DROP_BAD_EN
    chk("t6_level", level, 0);
    chk("t6_valid", rd_valid, 0);
`else
    chk("t6_level", level, 1);
    chk("t6_valid", rd_valid, 1);
    chk("t6_data", rd_data, 8'h3C);
    chk("t6_err", rd_err, 1);
`endif
    drain();
    tick();

    go = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
